// File: rtl/pn_command_sequencer.sv
// Buffers the Pn parameters of one control sequence and replays them as INIT, EMIT..., FINAL strobes with idle gaps.
// Optional statistics counters are built when CMD_SEQ_STATS_EN is defined.
module pn_command_sequencer #(
    parameter int MAX_PARAMS   = 16,
    parameter int GAP_CYCLES   = 1,
    parameter int CMD_W        = 6,
    parameter int INIT_PN_CODE = 1,
    parameter int EMIT_PN_CODE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pn_valid,
    input  logic [7:0]       pn_data,
    output logic             pn_ready,
    input  logic             cmd_valid,
    input  logic [CMD_W-1:0] cmd_code,
    output logic             cmd_ready,
    output logic             strobe_o,
    output logic [CMD_W-1:0] cmd_type_o,
    output logic [7:0]       pns_o,
    output logic             busy_o,
    output logic             overflow_o
`ifdef CMD_SEQ_STATS_EN
    ,
    output logic [15:0]      seq_count_o,
    output logic [7:0]       drop_count_o
`endif
);

    // state   | meaning
    // IDLE    | accepting Pn into the FIFO, waiting for the final command
    // INIT    | INIT strobe on the outputs this cycle
    // GAP     | idle spacing after a strobe, then go to follow_q
    // EMIT    | EMIT strobe carrying one buffered Pn
    // FINAL   | final command strobe carrying the last emitted Pn
    localparam int AW = $clog2(MAX_PARAMS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_EMIT  = 3'd3;
    localparam logic [2:0] S_FINAL = 3'd4;

    localparam logic [3:0]       GAP_LOAD = 4'(GAP_CYCLES - 1);
    localparam logic [CMD_W-1:0] INIT_C   = CMD_W'(INIT_PN_CODE);
    localparam logic [CMD_W-1:0] EMIT_C   = CMD_W'(EMIT_PN_CODE);

    logic [2:0]       state_q, state_d;
    logic [2:0]       follow_q, follow_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [CMD_W-1:0] cmd_code_q, cmd_code_d;
    logic [7:0]       last_pn_q, last_pn_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             strobe_q, strobe_d;
    logic [CMD_W-1:0] type_q, type_d;
    logic [7:0]       pns_q, pns_d;
    logic [7:0]       mem_q [MAX_PARAMS];

    logic             mem_we;
    logic             fifo_empty;
    logic             fifo_full;
    logic             enter;
    logic [2:0]       target;
    logic [2:0]       follow;
    logic [7:0]       pn_head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // An empty FIFO on the first EMIT stands in for the default Pn of 0.
    assign pn_head    = fifo_empty ? 8'd0 : mem_q[rd_ptr_q[AW-1:0]];

    assign pn_ready   = (state_q == S_IDLE);
    assign cmd_ready  = (state_q == S_IDLE);
    assign busy_o     = (state_q != S_IDLE);
    assign overflow_o = overflow_q;
    assign strobe_o   = strobe_q;
    assign cmd_type_o = type_q;
    assign pns_o      = pns_q;

    always_comb begin
        state_d    = state_q;
        follow_d   = follow_q;
        gap_cnt_d  = gap_cnt_q;
        cmd_code_d = cmd_code_q;
        last_pn_d  = last_pn_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        strobe_d   = 1'b0;
        type_d     = '0;
        pns_d      = 8'd0;
        mem_we     = 1'b0;
        enter      = 1'b0;
        target     = S_IDLE;
        follow     = S_IDLE;

        case (state_q)
            S_IDLE: begin
                // Pn is written in the same cycle as the command, so it joins this sequence.
                if (pn_valid) begin
                    if (!fifo_full) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (cmd_valid) begin
                    cmd_code_d = cmd_code;
                    enter      = 1'b1;
                    target     = S_INIT;
                end
            end
            S_INIT, S_EMIT, S_FINAL: begin
                if (state_q == S_INIT)
                    follow = S_EMIT;
                else if (state_q == S_EMIT)
                    follow = fifo_empty ? S_FINAL : S_EMIT;
                else
                    follow = S_IDLE;
                if (GAP_CYCLES == 0) begin
                    enter  = 1'b1;
                    target = follow;
                end else begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_LOAD;
                    follow_d  = follow;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    enter  = 1'b1;
                    target = follow_q;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                enter  = 1'b1;
                target = S_IDLE;
            end
        endcase

        if (enter) begin
            state_d = target;
            case (target)
                S_INIT: begin
                    strobe_d = 1'b1;
                    type_d   = INIT_C;
                end
                S_EMIT: begin
                    strobe_d  = 1'b1;
                    type_d    = EMIT_C;
                    pns_d     = pn_head;
                    last_pn_d = pn_head;
                    if (!fifo_empty)
                        rd_ptr_d = rd_ptr_q + 1'b1;
                end
                S_FINAL: begin
                    strobe_d = 1'b1;
                    type_d   = cmd_code_q;
                    pns_d    = last_pn_q;
                end
                default: begin
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    overflow_d = 1'b0;
                    last_pn_d  = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            follow_q   <= S_IDLE;
            gap_cnt_q  <= 4'd0;
            cmd_code_q <= '0;
            last_pn_q  <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            strobe_q   <= 1'b0;
            type_q     <= '0;
            pns_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            follow_q   <= follow_d;
            gap_cnt_q  <= gap_cnt_d;
            cmd_code_q <= cmd_code_d;
            last_pn_q  <= last_pn_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            strobe_q   <= strobe_d;
            type_q     <= type_d;
            pns_q      <= pns_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[wr_ptr_q[AW-1:0]] <= pn_data;
    end

`ifdef CMD_SEQ_STATS_EN
    logic        pn_drop;
    logic        seq_inc;
    logic [15:0] seq_count_q;
    logic [7:0]  drop_count_q;

    assign pn_drop      = (state_q == S_IDLE) && pn_valid && fifo_full;
    assign seq_inc      = enter && (target == S_FINAL);
    assign seq_count_o  = seq_count_q;
    assign drop_count_o = drop_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_count_q  <= 16'd0;
            drop_count_q <= 8'd0;
        end else begin
            if (seq_inc)
                seq_count_q <= seq_count_q + 16'd1;
            if (pn_drop && (drop_count_q != 8'hFF))
                drop_count_q <= drop_count_q + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pn_command_sequencer.sv
// Directed bench for pn_command_sequencer: one instance with GAP_CYCLES=1 and one with GAP_CYCLES=0 share the stimulus.
module tb_pn_command_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pn_valid = 1'b0;
    logic [7:0] pn_data = 8'd0;
    logic       cmd_valid = 1'b0;
    logic [5:0] cmd_code = 6'd0;

    logic       pn_ready, cmd_ready, strobe_o, busy_o, overflow_o;
    logic [5:0] cmd_type_o;
    logic [7:0] pns_o;
    logic       g_pn_ready, g_cmd_ready, g_strobe_o, g_busy_o, g_overflow_o;
    logic [5:0] g_cmd_type_o;
    logic [7:0] g_pns_o;
`ifdef CMD_SEQ_STATS_EN
    logic [15:0] seq_count_o, g_seq_count_o;
    logic [7:0]  drop_count_o, g_drop_count_o;
`endif

    pn_command_sequencer #(.GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .pn_valid(pn_valid), .pn_data(pn_data), .pn_ready(pn_ready),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cmd_ready),
        .strobe_o(strobe_o), .cmd_type_o(cmd_type_o), .pns_o(pns_o),
        .busy_o(busy_o), .overflow_o(overflow_o)
`ifdef CMD_SEQ_STATS_EN
        , .seq_count_o(seq_count_o), .drop_count_o(drop_count_o)
`endif
    );

    pn_command_sequencer #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .pn_valid(pn_valid), .pn_data(pn_data), .pn_ready(g_pn_ready),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(g_cmd_ready),
        .strobe_o(g_strobe_o), .cmd_type_o(g_cmd_type_o), .pns_o(g_pns_o),
        .busy_o(g_busy_o), .overflow_o(g_overflow_o)
`ifdef CMD_SEQ_STATS_EN
        , .seq_count_o(g_seq_count_o), .drop_count_o(g_drop_count_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    int s_cyc [0:63];
    int s_type [0:63];
    int s_pns [0:63];
    int n_s = 0;
    int acc [0:7];
    int n_acc = 0;
    int rdy = -1;
    int n_b2b = 0;
    int n_leak = 0;
    logic prev_strobe = 1'b0;

    int g_cyc [0:63];
    int g_type [0:63];
    int g_pns [0:63];
    int g_n = 0;
    int g_acc0 = -1;
    int g_rdy = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            n_s = 0; n_acc = 0; rdy = -1; prev_strobe = 1'b0;
        end else begin
            if (strobe_o) begin
                if (n_s < 64) begin
                    s_cyc[n_s] = cyc; s_type[n_s] = int'(cmd_type_o); s_pns[n_s] = int'(pns_o);
                end
                n_s++;
                if (prev_strobe) n_b2b++;
            end else if (cmd_type_o != 6'd0 || pns_o != 8'd0) begin
                n_leak++;
            end
            prev_strobe = strobe_o;
            if (cmd_valid && cmd_ready && n_acc < 8) begin
                acc[n_acc] = cyc; n_acc++;
            end
            if (n_acc > 0 && rdy < 0 && pn_ready && cyc > acc[0]) rdy = cyc;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            g_n = 0; g_acc0 = -1; g_rdy = -1;
        end else begin
            if (g_strobe_o) begin
                if (g_n < 64) begin
                    g_cyc[g_n] = cyc; g_type[g_n] = int'(g_cmd_type_o); g_pns[g_n] = int'(g_pns_o);
                end
                g_n++;
            end
            if (cmd_valid && g_cmd_ready && g_acc0 < 0) g_acc0 = cyc;
            if (g_acc0 >= 0 && g_rdy < 0 && g_pn_ready && cyc > g_acc0) g_rdy = cyc;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; pn_valid = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pn(input logic [7:0] v);
        pn_valid = 1'b1; pn_data = v;
        @(posedge clk);
        #1;
        pn_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [5:0] c);
        bit ok;
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_code = c;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (!ok) check("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state while rst is still asserted
        repeat (2) @(negedge clk);
        check("rst_pn_ready", int'(pn_ready), 1);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_strobe", int'(strobe_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_overflow", int'(overflow_o), 0);
        check("rst_type_pns", int'(cmd_type_o) + int'(pns_o), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two Pn then SETDEC
        send_pn(8'd6);
        send_pn(8'd25);
        send_cmd(6'h12);
        wait_cycles(20);
        check("t1_nstrobes", n_s, 4);
        check("t1_init_cyc", s_cyc[0] - acc[0], 1);
        check("t1_init_type", s_type[0], 1);
        check("t1_init_pns", s_pns[0], 0);
        check("t1_emit1_cyc", s_cyc[1] - acc[0], 3);
        check("t1_emit1_type", s_type[1], 2);
        check("t1_emit1_pns", s_pns[1], 6);
        check("t1_emit2_cyc", s_cyc[2] - acc[0], 5);
        check("t1_emit2_pns", s_pns[2], 25);
        check("t1_final_cyc", s_cyc[3] - acc[0], 7);
        check("t1_final_type", s_type[3], 'h12);
        check("t1_final_pns", s_pns[3], 25);
        check("t1_ready_cyc", rdy - acc[0], 9);
        check("t1g0_nstrobes", g_n, 4);
        check("t1g0_emit2_cyc", g_cyc[2] - g_acc0, 3);
        check("t1g0_final_cyc", g_cyc[3] - g_acc0, 4);
        check("t1g0_ready_cyc", g_rdy - g_acc0, 5);

        // RESETMODE with no Pn
        do_reset();
        send_cmd(6'h21);
        wait_cycles(15);
        check("t2g0_nstrobes", g_n, 3);
        check("t2g0_init_cyc", g_cyc[0] - g_acc0, 1);
        check("t2g0_emit_cyc", g_cyc[1] - g_acc0, 2);
        check("t2g0_emit_type", g_type[1], 2);
        check("t2g0_emit_pns", g_pns[1], 0);
        check("t2g0_final_cyc", g_cyc[2] - g_acc0, 3);
        check("t2g0_final_type", g_type[2], 'h21);
        check("t2g0_final_pns", g_pns[2], 0);
        check("t2g0_ready_cyc", g_rdy - g_acc0, 4);
        check("t2_final_cyc", s_cyc[2] - acc[0], 5);
        check("t2_ready_cyc", rdy - acc[0], 7);

        // 18 Pn into a 16-deep buffer
        do_reset();
        for (int i = 1; i <= 18; i++) send_pn(8'(i));
        check("t3_overflow_idle", int'(overflow_o), 1);
        check("t3_ready_after_drop", int'(pn_ready), 1);
`ifdef CMD_SEQ_STATS_EN
        check("t3_drop_count", int'(drop_count_o), 2);
`endif
        send_cmd(6'h2A);
        check("t3_busy", int'(busy_o), 1);
        check("t3_overflow_busy", int'(overflow_o), 1);
        wait_cycles(60);
        check("t3_overflow_cleared", int'(overflow_o), 0);
        check("t3_nstrobes", n_s, 18);
        for (int k = 1; k <= 16; k++) check($sformatf("t3_emit%0d_pns", k), s_pns[k], k);
        check("t3_final_type", s_type[17], 'h2A);
        check("t3_final_pns", s_pns[17], 16);
`ifdef CMD_SEQ_STATS_EN
        check("t3_seq_count", int'(seq_count_o), 1);
        check("t3_drop_count_kept", int'(drop_count_o), 2);
`endif

        // Pn and SETMODE in the same cycle
        do_reset();
        pn_valid = 1'b1; pn_data = 8'd4; cmd_valid = 1'b1; cmd_code = 6'h05;
        @(posedge clk);
        #1;
        pn_valid = 1'b0; cmd_valid = 1'b0;
        wait_cycles(15);
        check("t4_nstrobes", n_s, 3);
        check("t4_emit_pns", s_pns[1], 4);
        check("t4_final_type", s_type[2], 5);
        check("t4_final_pns", s_pns[2], 4);

        // Reset between EMIT 1 and EMIT 2 of 3
        do_reset();
        send_pn(8'd7);
        send_pn(8'd8);
        send_pn(8'd9);
        send_cmd(6'h12);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (n_s >= 2) break;
        end
        check("t5_reached_emit1", n_s, 2);
        rst = 1'b1;
        #1;
        check("t5_strobe_in_rst", int'(strobe_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_cycles(20);
        check("t5_no_strobes", n_s, 0);
        check("t5_pn_ready", int'(pn_ready), 1);
        check("t5_busy", int'(busy_o), 0);
        send_pn(8'd3);
        send_cmd(6'h12);
        wait_cycles(15);
        check("t5_new_nstrobes", n_s, 3);
        check("t5_new_emit_cyc", s_cyc[1] - acc[0], 3);
        check("t5_new_emit_pns", s_pns[1], 3);
        check("t5_new_final_pns", s_pns[2], 3);
`ifdef CMD_SEQ_STATS_EN
        check("t5_seq_count", int'(seq_count_o), 1);
`endif

        // cmd_valid held across a busy sequence
        do_reset();
        cmd_valid = 1'b1; cmd_code = 6'h12;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (n_acc >= 2) break;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_cycles(15);
        check("t6_n_accepts", n_acc, 2);
        check("t6_accept_gap", acc[1] - acc[0], 7);
        check("t6_accept_at_ready", acc[1], rdy);
        check("t6_nstrobes", n_s, 6);
        check("t6_init2_cyc", s_cyc[3] - acc[1], 1);
        check("t6_init2_type", s_type[3], 1);

        check("no_back_to_back_strobes", n_b2b, 0);
        check("outputs_zero_without_strobe", n_leak, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
